// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: STAGES registered carry-chain chunks with a valid/ready stream interface.
// Define PIPELINED_ADDSUB_SATURATE_EN to clamp signed-overflowing results to the saturation value.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 100,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned Chunk = (WIDTH + STAGES - 1) / STAGES;

  logic w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo = k * Chunk;
    localparam int unsigned Hi = ((k + 1) * Chunk < WIDTH) ? (k + 1) * Chunk : WIDTH;

    logic [WIDTH-1:0] w_a_in, w_b_in, w_s_in, w_s;
    logic             w_v_in, w_c_in, w_c;

    logic             r_vld;
    logic [WIDTH-1:0] r_a, r_b, r_s;
    logic             r_cy;

    // b is inverted once on entry; later stages carry the effective operand
    if (k == 0) begin : g_first
      assign w_v_in = in_valid;
      assign w_a_in = a;
      assign w_b_in = sub ? ~b : b;
      assign w_s_in = '0;
      assign w_c_in = cin;
    end else begin : g_next
      assign w_v_in = g_stage[k-1].r_vld;
      assign w_a_in = g_stage[k-1].r_a;
      assign w_b_in = g_stage[k-1].r_b;
      assign w_s_in = g_stage[k-1].r_s;
      assign w_c_in = g_stage[k-1].r_cy;
    end

    if (Lo < WIDTH) begin : g_chunk
      localparam int unsigned Wd = Hi - Lo;
      logic [Wd:0] w_add;

      assign w_add = {1'b0, w_a_in[Hi-1:Lo]} + {1'b0, w_b_in[Hi-1:Lo]} + {{Wd{1'b0}}, w_c_in};
      assign w_c   = w_add[Wd];

      always_comb begin
        w_s          = w_s_in;
        w_s[Hi-1:Lo] = w_add[Wd-1:0];
      end
    end else begin : g_empty
      assign w_s = w_s_in;
      assign w_c = w_c_in;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_a   <= '0;
        r_b   <= '0;
        r_s   <= '0;
        r_cy  <= 1'b0;
      end else if (w_adv) begin
        r_vld <= w_v_in;
        r_a   <= w_a_in;
        r_b   <= w_b_in;
        r_s   <= w_s;
        r_cy  <= w_c;
      end
    end
  end

  logic [WIDTH-1:0] w_fin_s, w_fin_a, w_fin_b;
  logic             w_fin_c, w_ovf, w_unused_ops;

  assign w_fin_s = g_stage[STAGES-1].r_s;
  assign w_fin_a = g_stage[STAGES-1].r_a;
  assign w_fin_b = g_stage[STAGES-1].r_b;
  assign w_fin_c = g_stage[STAGES-1].r_cy;

  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign w_ovf        = w_fin_c ^ (w_fin_s[WIDTH-1] ^ w_fin_a[WIDTH-1] ^ w_fin_b[WIDTH-1]);
  assign w_unused_ops = ^{w_fin_a[WIDTH-2:0], w_fin_b[WIDTH-2:0]};

  assign out_valid = g_stage[STAGES-1].r_vld;
  assign w_adv     = out_ready | ~out_valid;
  assign in_ready  = w_adv;
  assign cout      = w_fin_c;
  assign ovf       = w_ovf;

`ifdef PIPELINED_ADDSUB_SATURATE_EN
  always_comb begin
    sum = w_fin_s;
    if (w_ovf) begin
      sum = w_fin_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum = w_fin_s;
`endif

endmodule
